// File: rtl/stack_arb_ctrl.sv
// stack_arb_ctrl: two-requester round-robin arbiter in front of a single-port
// stack RAM. Push/pop requests are granted combinationally in IDLE; a pop
// spends one POP_WAIT cycle waiting for the RAM read before rvalid fires.
module stack_arb_ctrl #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          req1,
   input  logic          op0,
   input  logic          op1,
   input  logic [31:0]   wdata0,
   input  logic [31:0]   wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   output logic [31:0]   rdata,
   output logic          rvalid,
   output logic          rid,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          err,
   output logic          err_id
);

   typedef enum logic {IDLE = 1'b0, POP_WAIT = 1'b1} state_t;

   state_t        r_state, w_state_nxt;
   logic [AW:0]   r_sp;
   logic          r_last;     // requester granted most recently
   logic          r_arm;      // set at the first edge after reset release
   logic          r_pop_id;
   logic [31:0]   r_rdata;
   logic          r_rvalid, r_rid, r_err, r_err_id;

   logic          w_full, w_empty, w_grant, w_gid, w_op;
   logic          w_we, w_popok, w_bad;
   logic [AW-1:0] w_addr;
   logic [31:0]   w_wdata;

   assign w_full  = (r_sp == (AW+1)'(DEPTH));
   assign w_empty = (r_sp == '0);

   // Arbitration, next state and RAM port; grants only in IDLE once armed
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_gid       = 1'b0;
      w_op        = 1'b0;
      w_we        = 1'b0;
      w_popok     = 1'b0;
      w_bad       = 1'b0;
      w_addr      = r_sp[AW-1:0];
      w_wdata     = wdata0;
      case (r_state)
         IDLE: begin
            if (r_arm) begin
               w_grant = req0 | req1;
               w_gid   = (req0 && req1) ? ~r_last : req1;
               w_op    = w_gid ? op1 : op0;
               w_wdata = w_gid ? wdata1 : wdata0;
               if (w_grant) begin
                  if (w_op) begin
                     if (w_full) w_bad = 1'b1;
                     else        w_we  = 1'b1;
                  end else if (w_empty) begin
                     w_bad = 1'b1;
                  end else begin
                     w_popok     = 1'b1;
                     w_addr      = r_sp[AW-1:0] - AW'(1);
                     w_state_nxt = POP_WAIT;
                  end
               end
            end
         end
         POP_WAIT: w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Stack pointer, arbitration history and grant arming
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sp     <= '0;
         r_last   <= 1'b1;
         r_arm    <= 1'b0;
         r_pop_id <= 1'b0;
      end else begin
         r_arm <= 1'b1;
         if (w_we)         r_sp <= r_sp + (AW+1)'(1);
         else if (w_popok) r_sp <= r_sp - (AW+1)'(1);
         if (w_grant) r_last <= w_gid;
         if (w_popok) r_pop_id <= w_gid;
      end
   end

   // Pop result capture and error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
         r_rid    <= 1'b0;
         r_err    <= 1'b0;
         r_err_id <= 1'b0;
      end else begin
         r_rvalid <= (r_state == POP_WAIT);
         if (r_state == POP_WAIT) begin
            r_rdata <= mem_rdata;
            r_rid   <= r_pop_id;
         end
         r_err <= w_bad;
         if (w_bad) r_err_id <= w_gid;
      end
   end

   assign gnt0      = w_grant & ~w_gid;
   assign gnt1      = w_grant &  w_gid;
   assign mem_we    = w_we;
   assign mem_addr  = w_addr;
   assign mem_wdata = w_wdata;
   assign rdata     = r_rdata;
   assign rvalid    = r_rvalid;
   assign rid       = r_rid;
   assign full      = w_full;
   assign empty     = w_empty;
   assign count     = r_sp;
   assign err       = r_err;
   assign err_id    = r_err_id;

endmodule
